// File: rtl/parity_check_rx.sv
// Serial receiver/checker for parity-protected words.
// Frame on the line: start bit (0), DATA_W data bits LSB first, one parity bit.
// Only cycles with sin_valid=1 advance the deserialiser. A received word is held on a
// valid/ready output port. Define PARITY_ERR_CNT_EN to add the saturating err_cnt port.
module parity_check_rx #(
  parameter int unsigned DATA_W     = 4,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              par_err,
  output logic              overrun
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;
  logic              start_bit;
  logic              err_now;

  assign start_bit = sin_valid && !sin;
  assign err_now   = acc_q ^ sin;

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating parity error counter.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StParity && sin_valid && err_now && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`endif

  // Next-state and output-register logic for the receive FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      StIdle: begin
        if (start_bit) begin
          state_d = StData;
          idx_d   = '0;
          acc_d   = PARITY_ODD;
        end
      end
      StData: begin
        if (sin_valid) begin
          shreg_d[idx_q] = sin;
          acc_d          = acc_q ^ sin;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (sin_valid) begin
          data_d  = shreg_q;
          perr_d  = err_now;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        // The handshake is independent of sin_valid; a start bit in the same cycle
        // begins the next frame without a bubble.
        if (out_ready) begin
          valid_d = 1'b0;
          if (start_bit) begin
            state_d = StData;
            idx_d   = '0;
            acc_d   = PARITY_ODD;
          end else begin
            state_d = StIdle;
          end
        end else if (start_bit) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign par_err   = perr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// Bench for parity_check_rx: an even-parity and an odd-parity instance share the same
// stimulus; a frame-level model predicts outputs every cycle, plus literal spot checks.
module tb_parity_check_rx;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin = 1'b1;
  logic sin_valid = 1'b0;
  logic out_ready = 1'b0;

  logic [DW-1:0] e_data, o_data;
  logic e_valid, o_valid, e_perr, o_perr, e_ovr, o_ovr;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0] e_cnt, o_cnt;
`endif

  int n_tests = 0;
  int n_fail = 0;

  parity_check_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .out_data(e_data), .out_valid(e_valid), .out_ready(out_ready),
    .par_err(e_perr), .overrun(e_ovr)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(e_cnt)
`endif
  );

  parity_check_rx #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .out_data(o_data), .out_valid(o_valid), .out_ready(out_ready),
    .par_err(o_perr), .overrun(o_ovr)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(o_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect DATA_W+1 bits after a start bit, then evaluate.
  bit       m_init = 0;
  bit       m_busy = 0;
  bit       m_valid = 0;
  bit       m_ovr = 0;
  int       m_data = 0;
  int       m_perr_e = 0;
  int       m_perr_o = 0;
  int       m_cnt_e = 0;
  int       m_cnt_o = 0;
  bit       m_bits[$];

  always @(posedge clk) begin
    bit start;
    start = sin_valid && !sin;
    if (!rst_n) begin
      m_init = 1; m_busy = 0; m_valid = 0; m_ovr = 0;
      m_data = 0; m_perr_e = 0; m_perr_o = 0; m_cnt_e = 0; m_cnt_o = 0;
      m_bits.delete();
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0;
        if (start) begin
          m_busy = 1;
          m_bits.delete();
        end
      end else if (start) begin
        m_ovr = 1;
      end
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1;
        m_bits.delete();
      end
    end else if (sin_valid) begin
      m_bits.push_back(sin);
      if (m_bits.size() == DW + 1) begin
        int ones;
        m_data = 0;
        for (int i = 0; i < DW; i++) m_data += int'(m_bits[i]) << i;
        ones = $countones(m_data) + int'(m_bits[DW]);
        m_perr_e = ones % 2;
        m_perr_o = 1 - (ones % 2);
        if (m_perr_e == 1 && m_cnt_e < 255) m_cnt_e++;
        if (m_perr_o == 1 && m_cnt_o < 255) m_cnt_o++;
        m_valid = 1;
        m_busy = 0;
      end
    end
  end

  // Compare both instances against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_init) begin
      check("valid_even", int'(e_valid), int'(m_valid));
      check("valid_odd", int'(o_valid), int'(m_valid));
      check("data_even", int'(e_data), m_data);
      check("data_odd", int'(o_data), m_data);
      check("perr_even", int'(e_perr), m_perr_e);
      check("perr_odd", int'(o_perr), m_perr_o);
      check("ovr_even", int'(e_ovr), int'(m_ovr));
      check("ovr_odd", int'(o_ovr), int'(m_ovr));
`ifdef PARITY_ERR_CNT_EN
      check("cnt_even", int'(e_cnt), m_cnt_e);
      check("cnt_odd", int'(o_cnt), m_cnt_o);
`endif
    end
  end

  task automatic tick(input bit sv, input bit s, input bit r);
    sin_valid = sv;
    sin = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(0, 1, 0);
    tick(0, 1, 0);
    rst_n = 1'b1;
  endtask

  // Start bit with the given out_ready, then data LSB first and parity with out_ready=0.
  task automatic send_frame(input logic [DW-1:0] d, input bit p, input bit r_start);
    tick(1, 0, r_start);
    for (int i = 0; i < DW; i++) tick(1, d[i], 0);
    tick(1, p, 0);
  endtask

  initial begin
    do_reset();
    check("rst_valid", int'(e_valid), 0);
    check("rst_data", int'(e_data), 0);
    check("rst_perr", int'(e_perr), 0);
    check("rst_ovr", int'(e_ovr), 0);

    // 1: even frame 4'hB, parity 1, valid exactly after the parity bit
    tick(1, 0, 0);
    for (int i = 0; i < DW; i++) tick(1, (4'hB >> i) & 1, 0);
    check("t1_not_yet_valid", int'(e_valid), 0);
    tick(1, 1, 0);
    check("t1_valid", int'(e_valid), 1);
    check("t1_data", int'(e_data), 'hB);
    check("t1_perr_even", int'(e_perr), 0);
    check("t1_perr_odd", int'(o_perr), 1);
    tick(0, 1, 1);
    check("t1_consumed", int'(e_valid), 0);

    // 2: same frame, bad parity
    send_frame(4'hB, 0, 0);
    check("t2_data", int'(e_data), 'hB);
    check("t2_perr", int'(e_perr), 1);
`ifdef PARITY_ERR_CNT_EN
    check("t2_cnt", int'(e_cnt), 1);
`endif
    tick(0, 1, 1);

    // 3: odd parity on data 0
    send_frame(4'h0, 1, 0);
    check("t3_odd_ok", int'(o_perr), 0);
    check("t3_even_bad", int'(e_perr), 1);
    tick(0, 1, 1);
    send_frame(4'h0, 0, 0);
    check("t3_odd_bad", int'(o_perr), 1);
    tick(0, 1, 1);

    // 4: overrun while held
    send_frame(4'hB, 1, 0);
    tick(1, 1, 0);
    check("t4_idle_no_ovr", int'(e_ovr), 0);
    tick(1, 0, 0);
    check("t4_ovr", int'(e_ovr), 1);
    check("t4_data_kept", int'(e_data), 'hB);
    check("t4_still_valid", int'(e_valid), 1);
    tick(0, 1, 1);
    check("t4_valid_falls", int'(e_valid), 0);
    check("t4_ovr_sticky", int'(e_ovr), 1);

    // 5: back-to-back frames
    do_reset();
    send_frame(4'hB, 1, 0);
    check("t5_first", int'(e_data), 'hB);
    send_frame(4'h5, 0, 1);
    check("t5_second", int'(e_data), 5);
    check("t5_valid", int'(e_valid), 1);
    check("t5_no_ovr", int'(e_ovr), 0);
    tick(0, 1, 1);

    // 6: reset mid-frame, then a clean frame
    tick(1, 0, 0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    rst_n = 1'b0;
    tick(1, 0, 0);
    rst_n = 1'b1;
    check("t6_data_cleared", int'(e_data), 0);
    check("t6_valid_cleared", int'(e_valid), 0);
    send_frame(4'h3, 0, 0);
    check("t6_data", int'(e_data), 3);
    check("t6_perr", int'(e_perr), 0);
    tick(0, 1, 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
    end
    rst_n = 1'b1;

`ifdef PARITY_ERR_CNT_EN
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_frame(4'hB, 0, 0);
      tick(0, 1, 1);
    end
    check("cnt_saturated", int'(e_cnt), 255);
`endif

    tick(0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
